crc9_frame_checker: RTL and testbench
=====================================

Name: crc9_frame_checker

Overview:
- Receiver-side stage directly downstream of the serial CRC-9 generator.
- Accepts one 19-bit codeword per transaction: 10-bit payload followed by the 9-bit CRC.
- Re-runs the codeword MSB-first through a CRC-9 LFSR and returns the payload with a pass/fail flag.
- Uses valid/ready handshakes on both sides; processes one frame at a time with no overlap.

Parameters:
- DATA_W, 10, payload width in bits.
- CRC_W, 9, CRC width in bits.
- POLY, 9'h003, generator polynomial without the x^CRC_W term; default is g(x)=x^9+x+1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  codeword on in_data/in_crc is valid.
- in_ready  output  1  block can accept a codeword.
- in_data  input  DATA_W  received payload.
- in_crc  input  CRC_W  received CRC.
- out_valid  output  1  check result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  DATA_W  payload, passed through unchanged.
- crc_err  output  1  1 = remainder nonzero (frame corrupt).
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset (asynchronous, active-high; clock is clk):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out_data=0, crc_err=0, busy=0.
  - Shift register, remainder register and bit counter are all cleared.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, load shift_reg={in_data,in_crc} and out_data=in_data; clear the remainder and bit counter; go to SHIFT.
  - SHIFT: in_ready=0, busy=1. Each cycle consume bit b=shift_reg[MSB] and shift left. Update fb=rem[CRC_W-1]^b; rem={rem[CRC_W-2:0],0}^(fb?POLY:0).
  - SHIFT exit: when the counter reaches DATA_W+CRC_W-1 (18), go to DONE. crc_err = (next rem != 0), registered.
  - DONE: out_valid=1 and outputs are held stable. On out_valid&&out_ready, go to IDLE; in_ready returns to 1 on the following cycle.
- Latency: out_valid rises exactly DATA_W+CRC_W (19) clock edges after the accepting edge.
- Throughput: one frame per 21 cycles or more.
- Back-pressure: out_ready low holds DONE indefinitely. out_data/crc_err must not change; in_ready stays 0.
- in_valid while not in IDLE: ignored; no sampling of in_data.
- Reset mid-SHIFT or mid-DONE: frame is discarded and no out_valid pulse is produced.
- Counter width: $clog2(DATA_W+CRC_W). The counter must not wrap inside a frame.
- An all-zero codeword is valid (crc_err=0).

Optional Feature:
- Macro: CRC9_ERR_COUNT_EN.
- Defined:
  - Adds output err_count [15:0], reset to 0.
  - Increments by 1 on each out handshake with crc_err=1.
  - Saturates at 16'hFFFF with no wrap.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package crc9_pkg holds:
  - DATA_W, CRC_W, POLY and FRAME_W=DATA_W+CRC_W;
  - state enum {IDLE,SHIFT,DONE};
  - function crc_step(rem,bit,poly) returning the next remainder.
- One natural sub-module, crc9_lfsr:
  - inputs clk, reset, clr, en, bit_in;
  - output rem [CRC_W-1:0];
  - the same LFSR the generator side can share.
- The FSM, shift register and handshakes live in the top module.

Test Plan:
- Frame in_data=10'h001, in_crc=9'h003 -> out_valid 19 cycles after accept; out_data=10'h001, crc_err=0.
- Frame in_data=10'h001, in_crc=9'h002 (single-bit error) -> crc_err=1. With CRC9_ERR_COUNT_EN, err_count=1.
- Frame of all zeros -> crc_err=0. Frame 10'h000/9'h001 -> crc_err=1.
- Hold out_ready=0 for 5 cycles after out_valid -> out_valid, out_data and crc_err stable; in_ready=0 and in_valid pulses are ignored. After the handshake, in_ready=1 next cycle.
- Assert reset on the 7th SHIFT cycle of a frame -> all outputs at reset values, in_ready=1 after release, no out_valid. A following good frame passes.
- With CRC9_ERR_COUNT_EN: force err_count to 16'hFFFE, then send 3 bad frames -> count saturates at 16'hFFFF.

Source files
------------

// File: rtl/crc9_pkg.sv
// Shared CRC-9 constants, FSM state type and the one-bit LFSR step used by the frame checker.
package crc9_pkg;
  localparam int unsigned DATA_W  = 10;
  localparam int unsigned CRC_W   = 9;
  localparam int unsigned FRAME_W = DATA_W + CRC_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W);
  localparam logic [CRC_W-1:0] POLY = 9'h003;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // One MSB-first division step: feedback is the outgoing remainder MSB xor the incoming bit.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] rem,
                                                input logic             bit_in,
                                                input logic [CRC_W-1:0] poly);
    logic fb;
    fb = rem[CRC_W-1] ^ bit_in;
    return {rem[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction
endpackage

// File: rtl/crc9_frame_checker_if.sv
// Codeword-in / result-out handshake bundle of crc9_frame_checker (err_count with CRC9_ERR_COUNT_EN).
interface crc9_frame_checker_if;
  import crc9_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CRC_W-1:0]  in_crc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              crc_err;
  logic              busy;
`ifdef CRC9_ERR_COUNT_EN
  logic [15:0]       err_count;
`endif

  modport master (
    output in_valid, in_data, in_crc, out_ready,
    input  in_ready, out_valid, out_data, crc_err, busy
`ifdef CRC9_ERR_COUNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  in_valid, in_data, in_crc, out_ready,
    output in_ready, out_valid, out_data, crc_err, busy
`ifdef CRC9_ERR_COUNT_EN
    , output err_count
`endif
  );
endinterface

// File: rtl/crc9_lfsr.sv
// Serial CRC-9 remainder register, MSB-first; shared with the generator side.
module crc9_lfsr
  import crc9_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = crc9_pkg::POLY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] rem
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rem <= '0;
    else if (clr) rem <= '0;
    else if (en)  rem <= crc_step(rem, bit_in, POLY);
  end
endmodule

// File: rtl/crc9_frame_checker.sv
// CRC-9 receive checker: shifts a 19-bit codeword through the LFSR and flags a nonzero remainder.
// Build with CRC9_ERR_COUNT_EN for a saturating 16-bit error counter on the interface.
module crc9_frame_checker
  import crc9_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = crc9_pkg::POLY
) (
  input  logic           clk,
  input  logic           reset,
  crc9_frame_checker_if.slave bus
);
  state_t               state;
  logic [FRAME_W-1:0]   shift_reg;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CRC_W-1:0]     rem;
  logic [CRC_W-1:0]     rem_next;
  logic                 accept;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [DATA_W-1:0]    out_data_q;
  logic                 crc_err_q;
  logic                 busy_q;

  assign accept   = (state == IDLE) && bus.in_valid;
  // Remainder after the current bit, so the verdict registers on the same edge as DONE entry.
  assign rem_next = crc_step(rem, shift_reg[FRAME_W-1], POLY);

  crc9_lfsr #(.POLY(POLY)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .en     (state == SHIFT),
    .bit_in (shift_reg[FRAME_W-1]),
    .rem    (rem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      crc_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            shift_reg  <= {bus.in_data, bus.in_crc};
            out_data_q <= bus.in_data;
            bit_cnt    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
          if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
            bit_cnt     <= '0;
            crc_err_q   <= (rem_next != '0);
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.crc_err   = crc_err_q;
  assign bus.busy      = busy_q;

`ifdef CRC9_ERR_COUNT_EN
  logic [15:0] err_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
    end else if ((state == DONE) && bus.out_ready && crc_err_q && (err_count_q != '1)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign bus.err_count = err_count_q;
`endif
endmodule

// File: tb/tb_crc9_frame_checker.sv
// Directed scoreboard bench for crc9_frame_checker; honours CRC9_ERR_COUNT_EN when defined.
module tb_crc9_frame_checker;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;
  int   err_model = 0;
  logic [10:0] sb[$];

  crc9_frame_checker_if bus ();

  crc9_frame_checker #(.POLY(9'h003)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC by long division of payload*x^9 by x^9+x+1.
  function automatic logic [8:0] ref_crc(input logic [9:0] d);
    logic [18:0] v;
    logic [18:0] g;
    v = {d, 9'b0};
    for (int i = 18; i >= 9; i--) begin
      g = 19'h203 << (i - 9);
      if (v[i]) v = v ^ g;
    end
    return v[8:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] d, input logic [8:0] c);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    chk("in_ready_before_send", bus.in_ready, 1);
    bus.in_data  = d;
    bus.in_crc   = c;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    sb.push_back({d, (c != ref_crc(d))});
    chk("busy_shift", bus.busy, 1);
    chk("in_ready_shift", bus.in_ready, 0);
  endtask

  task automatic collect(input int hold);
    int n;
    logic [10:0] exp;
    logic [9:0]  d0;
    logic        e0;
    n = 0;
    while (!bus.out_valid && n < 40) begin tick(); n++; end
    chk("latency", n, 19);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
    chk("out_data", bus.out_data, exp[10:1]);
    chk("crc_err", bus.crc_err, exp[0]);
    chk("busy_done", bus.busy, 0);
    d0 = bus.out_data;
    e0 = bus.crc_err;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = ~d0;
      bus.in_crc   = 9'h1AA;
      tick();
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, d0);
      chk("hold_err", bus.crc_err, e0);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    if (exp[0] && err_model < 16'hFFFF) err_model++;
    chk("valid_drop", bus.out_valid, 0);
    chk("in_ready_after", bus.in_ready, 1);
`ifdef CRC9_ERR_COUNT_EN
    chk("err_count", bus.err_count, err_model);
`endif
  endtask

  initial begin
    int bad;
    logic [9:0] d;
    logic [8:0] c;
    logic [8:0] flip;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_crc    = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_crc_err", bus.crc_err, 0);
    chk("rst_busy", bus.busy, 0);
`ifdef CRC9_ERR_COUNT_EN
    chk("rst_err_count", bus.err_count, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    tick();

    send(10'h001, 9'h003); collect(0);
    send(10'h001, 9'h002); collect(0);
    send(10'h000, 9'h000); collect(0);
    send(10'h000, 9'h001); collect(0);
    send(10'h3FF, ref_crc(10'h3FF)); collect(0);

    // Back-pressure with in_valid pulses that must be ignored.
    send(10'h2A5, ref_crc(10'h2A5)); collect(5);
    repeat (3) begin
      tick();
      chk("no_spurious_accept", bus.busy, 0);
    end

    for (int k = 0; k < 6; k++) begin
      d = 10'($urandom_range(0, 1023));
      c = ref_crc(d);
      flip = 9'b1 << $urandom_range(0, 8);
      if (k[0]) c = c ^ flip;
      send(d, c);
      collect(k % 3);
    end

    // Reset during the 7th SHIFT cycle discards the frame.
    send(10'h155, ref_crc(10'h155));
    repeat (6) tick();
    reset = 1'b1;
    void'(sb.pop_back());
    err_model = 0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_crc_err", bus.crc_err, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (30) begin
      tick();
      if (bus.out_valid !== 1'b0) bad++;
    end
    chk("midrst_no_out_valid", bad, 0);
    chk("midrst_in_ready_after", bus.in_ready, 1);
    send(10'h0F0, ref_crc(10'h0F0)); collect(0);

`ifdef CRC9_ERR_COUNT_EN
    force dut.err_count_q = 16'hFFFE;
    #1;
    release dut.err_count_q;
    err_model = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      send(10'h001, 9'h002);
      collect(0);
    end
    chk("err_count_sat", bus.err_count, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
